// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI responder.
package spi_pkg;

    localparam int SPI_DATA_WIDTH  = 32;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sync.sv
// One synchronizer line: STAGES flops bringing an external SPI pin into the clk domain.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: receives a DATA_WIDTH-bit frame MSB-first on MOSI while
// returning a preloaded word on MISO; flags frames of the wrong length.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy,
    input  logic                  spi_clk,
    input  logic                  cs_n,
    input  logic                  spi_i,
    output logic                  spi_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

    logic sclk_s, cs_s, mosi_s;
    logic rise, fall, cs_fall, cs_rise;

    logic                  sclk_prev_q, sclk_prev_d;
    logic                  cs_prev_q, cs_prev_d;
    spi_slv_state_t        state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_reg_q, tx_reg_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;

    // Identical pipeline depth on all three lines keeps MOSI aligned with the clock edge.
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(spi_clk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_i), .q(mosi_s)
    );

    assign rise    =  sclk_s & ~sclk_prev_q;
    assign fall    = ~sclk_s &  sclk_prev_q;
    assign cs_fall = ~cs_s   &  cs_prev_q;
    assign cs_rise =  cs_s   & ~cs_prev_q;

    always_comb begin
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_reg_d    = tx_reg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_shift_d = tx_reg_q;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = ACTIVE;
                end else if (tx_load) begin
                    tx_reg_d = tx_data;
                end
            end
            ACTIVE: begin
                // End of frame takes priority over any SPI clock edge in the same cycle.
                if (cs_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_q == CNT_FULL) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (rise) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt_q != CNT_SAT) begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (fall) begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_reg_q    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_reg_q    <= tx_reg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign busy      = (state_q == ACTIVE);
    assign spi_o     = busy ? tx_shift_q[DATA_WIDTH-1] : tx_reg_q[DATA_WIDTH-1];
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master, a table of
// directed frames, hand-written corner sequences and randomized frames.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int DW   = 32;
    localparam int SYNC = SPI_SYNC_STAGES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_load = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;
    logic          spi_clk = 1'b0;
    logic          cs_n = 1'b1;
    logic          spi_i = 1'b0;
    logic          spi_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int valid_cnt    = 0;
    int err_cnt      = 0;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .busy(busy), .spi_clk(spi_clk), .cs_n(cs_n), .spi_i(spi_i), .spi_o(spi_o)
    );

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        int          load_mode;  // 0 none, 1 while busy, 2 at cs_fall, 3 idle before frame
        logic [31:0] load_word;
        logic [31:0] mosi;
        int          nbits;
        logic [31:0] exp_rx;
        int          exp_valid;
        int          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Behavioural master: MOSI changes one clk after the spi_clk rise, MISO is
    // sampled on the rise, and the frame ends by raising cs_n as spi_clk falls.
    task automatic applyStimulus(input int ratio, input logic [31:0] mosi, input int nbits,
                                 input int load_mode, input int load_bit, input logic [31:0] load_word,
                                 input int abort_bit, output logic [31:0] rd);
        int half;
        int nxt;
        half = ratio / 2;
        rd   = '0;
        if (load_mode == 3) begin
            tx_data = load_word;
            tx_load = 1'b1;
            tick(1);
            tx_load = 1'b0;
            tick(2);
        end
        cs_n    = 1'b0;
        spi_clk = 1'b0;
        spi_i   = mosi[31];
        for (int j = 0; j < half; j++) begin
            if (load_mode == 2 && j == SYNC) begin
                tx_data = load_word;
                tx_load = 1'b1;
            end else begin
                tx_load = 1'b0;
            end
            tick(1);
        end
        tx_load = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_bit) begin
                rst     = 1'b1;
                cs_n    = 1'b1;
                spi_clk = 1'b0;
                spi_i   = 1'b0;
                return;
            end
            spi_clk = 1'b1;
            rd = {rd[30:0], spi_o};
            tick(1);
            nxt   = i + 1;
            spi_i = (nxt < 32) ? mosi[31 - nxt] : 1'b0;
            for (int j = 0; j < half - 1; j++) begin
                if (load_mode == 1 && i == load_bit && j == 0) begin
                    tx_data = load_word;
                    tx_load = 1'b1;
                end else begin
                    tx_load = 1'b0;
                end
                tick(1);
            end
            tx_load = 1'b0;
            if (i < nbits - 1) begin
                spi_clk = 1'b0;
                tick(half);
            end
        end
        cs_n    = 1'b1;
        spi_clk = 1'b0;
        spi_i   = 1'b0;
        tick(8);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] mosi;
        logic [31:0] word;
        logic [31:0] model_tx;
        int          v0;
        int          e0;
        int          mode;

        vecs[0]  = '{3, 32'hA5A5_0F0F, 32'h1234_5678, 32, 32'h1234_5678, 1, 0, 32'hA5A5_0F0F};
        vecs[1]  = '{0, 32'h0,         32'hFFFF_0000, 32, 32'hFFFF_0000, 1, 0, 32'hA5A5_0F0F};
        vecs[2]  = '{0, 32'h0,         32'h0000_FFFF, 32, 32'h0000_FFFF, 1, 0, 32'hA5A5_0F0F};
        vecs[3]  = '{0, 32'h0,         32'hCAFE_BABE, 10, 32'h0000_FFFF, 0, 1, 32'h0000_0296};
        vecs[4]  = '{0, 32'h0,         32'h1357_9BDF, 32, 32'h1357_9BDF, 1, 0, 32'hA5A5_0F0F};
        vecs[5]  = '{1, 32'hDEAD_BEEF, 32'h2468_ACE0, 32, 32'h2468_ACE0, 1, 0, 32'hA5A5_0F0F};
        vecs[6]  = '{0, 32'h0,         32'h1111_1111, 32, 32'h1111_1111, 1, 0, 32'hA5A5_0F0F};
        vecs[7]  = '{3, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32, 32'h0F0F_0F0F, 1, 0, 32'hDEAD_BEEF};
        vecs[8]  = '{2, 32'h55AA_55AA, 32'h8765_4321, 32, 32'h8765_4321, 1, 0, 32'hDEAD_BEEF};
        vecs[9]  = '{0, 32'h0,         32'hFEDC_BA98, 32, 32'hFEDC_BA98, 1, 0, 32'hDEAD_BEEF};
        vecs[10] = '{0, 32'h0,         32'h0000_0000, 33, 32'hFEDC_BA98, 0, 1, 32'hBD5B_7DDE};

        tick(3);
        checkOutput("reset spi_o", {31'b0, spi_o}, 32'h0);
        checkOutput("reset rx_data", rx_data, 32'h0);
        checkOutput("reset rx_valid", {31'b0, rx_valid}, 32'h0);
        checkOutput("reset frame_err", {31'b0, frame_err}, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        tick(2);

        // Idle load is visible on MISO one cycle later.
        tx_data = 32'h8000_0000;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        checkOutput("spi_o after load msb1", {31'b0, spi_o}, 32'h1);
        tx_data = 32'h7FFF_FFFF;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        checkOutput("spi_o after load msb0", {31'b0, spi_o}, 32'h0);

        // busy latency and an empty frame reported as an error.
        cs_n = 1'b0;
        tick(SYNC);
        checkOutput("busy before latency", {31'b0, busy}, 32'h0);
        tick(1);
        checkOutput("busy after cs_n fall", {31'b0, busy}, 32'h1);
        cs_n = 1'b1;
        tick(SYNC);
        checkOutput("busy held after cs_n rise", {31'b0, busy}, 32'h1);
        checkOutput("frame_err not yet", {31'b0, frame_err}, 32'h0);
        tick(1);
        checkOutput("busy after cs_n rise", {31'b0, busy}, 32'h0);
        checkOutput("frame_err empty frame", {31'b0, frame_err}, 32'h1);
        tick(1);
        checkOutput("frame_err one cycle", {31'b0, frame_err}, 32'h0);
        tick(5);

        for (int k = 0; k < 11; k++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            applyStimulus(16, vecs[k].mosi, vecs[k].nbits, vecs[k].load_mode, 5,
                          vecs[k].load_word, -1, rd);
            checkOutput($sformatf("vec%0d master read", k), rd, vecs[k].exp_rd);
            checkOutput($sformatf("vec%0d rx_data", k), rx_data, vecs[k].exp_rx);
            checkOutput($sformatf("vec%0d rx_valid pulses", k), 32'(valid_cnt - v0), 32'(vecs[k].exp_valid));
            checkOutput($sformatf("vec%0d frame_err pulses", k), 32'(err_cnt - e0), 32'(vecs[k].exp_err));
            checkOutput($sformatf("vec%0d busy idle", k), {31'b0, busy}, 32'h0);
        end

        // Reset in the middle of a frame; the master is reset along with the slave.
        applyStimulus(16, 32'hABCD_EF01, 32, 0, 0, 32'h0, 17, rd);
        #1;
        checkOutput("midreset spi_o", {31'b0, spi_o}, 32'h0);
        checkOutput("midreset rx_data", rx_data, 32'h0);
        checkOutput("midreset rx_valid", {31'b0, rx_valid}, 32'h0);
        checkOutput("midreset frame_err", {31'b0, frame_err}, 32'h0);
        checkOutput("midreset busy", {31'b0, busy}, 32'h0);
        tick(3);
        rst = 1'b0;
        e0 = err_cnt;
        v0 = valid_cnt;
        tick(10);
        checkOutput("after reset no err", 32'(err_cnt - e0), 32'h0);
        checkOutput("after reset no valid", 32'(valid_cnt - v0), 32'h0);
        applyStimulus(16, 32'h600D_F00D, 32, 3, 0, 32'h0000_0001, -1, rd);
        checkOutput("post reset master read", rd, 32'h0000_0001);
        checkOutput("post reset rx_data", rx_data, 32'h600D_F00D);
        model_tx = 32'h0000_0001;

        // Random frames at the minimum ratio against the word-level model.
        for (int n = 0; n < 100; n++) begin
            mosi = $urandom;
            word = $urandom;
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                model_tx = word;
                mode = 3;
            end else if (mode == 1) begin
                mode = 1;
            end else begin
                mode = 0;
            end
            v0 = valid_cnt;
            e0 = err_cnt;
            applyStimulus(8, mosi, 32, mode, int'($urandom_range(0, 31)), word, -1, rd);
            checkOutput($sformatf("rand%0d master read", n), rd, model_tx);
            checkOutput($sformatf("rand%0d rx_data", n), rx_data, mosi);
            checkOutput($sformatf("rand%0d rx_valid pulses", n), 32'(valid_cnt - v0), 32'h1);
            checkOutput($sformatf("rand%0d frame_err pulses", n), 32'(err_cnt - e0), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

- Responder end of the team's SPI link, driven by the SPI master.
- Runs on the same system clock as the master. The master's `spi_clk`, `cs_n` and MOSI lines are treated as inputs: each is registered through a synchronizer, then edge-detected.
- Receives a DATA_WIDTH-bit frame MSB-first on MOSI and returns a host-preloaded word MSB-first on MISO in the same frame.
- Reports the received word, and flags frames aborted short or overlong.

## Interface
- `DATA_WIDTH`, 32: frame length in bits. Must equal the master's frame width.
- `SYNC_STAGES`, 2: number of synchronizer flops on each SPI input. Minimum 2.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `tx_data`  in  DATA_WIDTH: word to return to the master in the next frame.
- `tx_load`  in  1: one-cycle strobe that captures `tx_data` into `tx_reg`. Ignored while `busy`=1.
- `rx_data`  out  DATA_WIDTH: last complete received frame. Holds its value until the next good frame.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` is updated.
- `frame_err`  out  1: one-cycle pulse when a frame ends with a bit count other than DATA_WIDTH.
- `busy`  out  1: high while a frame is in progress (state ACTIVE).
- `spi_clk`  in  1: SPI clock from the master.
- `cs_n`  in  1: active-low chip select from the master.
- `spi_i`  in  1: MOSI, data from the master.
- `spi_o`  out  1: MISO, data to the master.

## Operation
- Synchronizers: `spi_clk`, `cs_n` and `spi_i` each pass through identical SYNC_STAGES-deep pipelines, producing `sclk_s`, `cs_s` and `mosi_s`.
  - Reset values: `sclk_s`=0, `cs_s`=1, `mosi_s`=0.
  - One extra register per line holds the previous synchronized value.
  - Edge events `rise`, `fall`, `cs_fall`, `cs_rise` are each a one-cycle compare of the synchronized value against that previous value.
- Sampling rule:
  - MOSI is captured into `rx_shift` on `rise`: `rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s}`.
  - This is valid because the master changes MOSI one `clk` after the `spi_clk` rising edge. The matched pipelines therefore present the pre-shift bit to the slave on the same cycle `rise` is detected.
- Drive rule:
  - MISO is updated on `fall`: `tx_shift <= tx_shift << 1`.
  - The master samples MISO on its `spi_clk` rising edge, which is at least half a period minus SYNC_STAGES+1 cycles after the update.
- `spi_o` source: `tx_reg[MSB]` in IDLE; `tx_shift[MSB]` in ACTIVE.
- States:
  - IDLE:
    - `tx_load` writes `tx_reg`.
    - On `cs_fall`: load `tx_shift` from `tx_reg`, clear `bit_cnt` and `rx_shift`, go to ACTIVE.
  - ACTIVE:
    - Each `rise` shifts `rx_shift` and increments `bit_cnt`. `bit_cnt` saturates at DATA_WIDTH+1.
    - Each `fall` shifts `tx_shift`.
    - On `cs_rise`, go to IDLE and:
      - if `bit_cnt`==DATA_WIDTH: `rx_data` <= `rx_shift` and pulse `rx_valid`;
      - otherwise: pulse `frame_err` and leave `rx_data` unchanged.
- `tx_reg` keeps its value after a frame, so an unreloaded word is resent in the next frame.
- Boundary conditions:
  - `cs_rise` and `fall` in the same cycle (the master ends a frame this way): `cs_rise` wins and the `tx_shift` update is dropped.
  - `cs_rise` and `rise` in the same cycle: the bit is not counted.
  - `tx_load` in the same cycle as `cs_fall`: the load is ignored and the frame uses the old `tx_reg`.
  - `cs_fall` while already ACTIVE: cannot occur; no action.
  - `rst` mid-frame: all state returns to reset values immediately. The master's remaining bits are not counted because no `cs_fall` is seen; the frame in progress is lost.

## Timing
- Reset values: `spi_o`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, `tx_reg`=0.
- `busy` rises SYNC_STAGES+1 cycles after `cs_n` falls, and falls SYNC_STAGES+1 cycles after `cs_n` rises.
- `rx_valid` and `frame_err` assert SYNC_STAGES+1 cycles after `cs_n` rises, for exactly one cycle.
- `spi_o` updates SYNC_STAGES+1 cycles after a falling edge of `spi_clk`.
- `tx_load` in IDLE: `tx_reg` updates on the same clock edge, and `spi_o` reflects it in the next cycle.
- Required spi_clk half-period: at least SYNC_STAGES+2 `clk` cycles. Master FREQUENCY_RATIO ≥ 8 with default parameters.

## Structure
- Package `spi_pkg`:
  - `SPI_DATA_WIDTH`=32;
  - state enum `spi_slv_state_t` {IDLE, ACTIVE};
  - `SPI_SYNC_STAGES`=2.
- Sub-module `spi_sync` (parameter STAGES, RESET_VAL): one synchronizer line with asynchronous reset, instantiated three times.
- Everything else (edge detect, FSM, shift registers, counter) lives in the top module.

## Test plan
- Basic exchange:
  - Stimulus: load `tx_data`=0xA5A5_0F0F; master (FREQUENCY_RATIO 16) sends 0x1234_5678.
  - Response: `rx_data`=0x1234_5678 with exactly one `rx_valid` pulse; master `data_rd`=0xA5A5_0F0F.
- Back-to-back frames:
  - Stimulus: two frames with no reload, master sending 0xFFFF_0000 then 0x0000_FFFF.
  - Response: two `rx_valid` pulses with matching `rx_data`; master reads 0xA5A5_0F0F both times.
- Short frame:
  - Stimulus: deassert `cs_n` after 10 rising edges.
  - Response: one `frame_err` pulse, no `rx_valid`, `rx_data` unchanged; the next full frame is received correctly.
- Load while busy:
  - Stimulus: `tx_load` with 0xDEAD_BEEF while `busy`=1.
  - Response: the current and next frame return the old word; a load after `busy`=0 takes effect.
- Reset mid-frame:
  - Stimulus: assert `rst` at bit 17.
  - Response: all outputs go to reset values immediately. A subsequent frame with `tx_data` 0x0000_0001 completes and the master reads 0x0000_0001.
- Minimum ratio:
  - Stimulus: FREQUENCY_RATIO 8, random data over 100 frames.
  - Response: every frame matches in both directions; no `frame_err`.
